// File: rtl/mem_bus_pkg.sv
// Shared encodings for the data-memory access interface.
package mem_bus_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_e;

endpackage

// File: rtl/mem_lane_align.sv
// Little-endian byte-lane steering for stores and extraction/extension for loads.
module mem_lane_align
   import mem_bus_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  addr_lo_i,
   input  logic        signed_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  wmask_c_o,
   output logic [31:0] wword_c_o,
   output logic [31:0] rdata_c_o,
   output logic        misalign_c_o
);

   logic [15:0] half_c;
   logic [7:0]  byte_c;

   always_comb begin
      half_c = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];
      byte_c = rword_i[8*addr_lo_i +: 8];
   end

   // The reserved size encoding is folded into the misalignment flag.
   always_comb begin
      wmask_c_o    = 4'b0000;
      wword_c_o    = wdata_i;
      rdata_c_o    = 32'h0;
      misalign_c_o = 1'b0;
      case (size_i)
         SIZE_WORD: begin
            wmask_c_o    = 4'b1111;
            rdata_c_o    = rword_i;
            misalign_c_o = (addr_lo_i != 2'b00);
         end
         SIZE_HALF: begin
            wmask_c_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            wword_c_o    = {2{wdata_i[15:0]}};
            rdata_c_o    = {{16{signed_i & half_c[15]}}, half_c};
            misalign_c_o = addr_lo_i[0];
         end
         SIZE_BYTE: begin
            wmask_c_o = 4'(4'b0001 << addr_lo_i);
            wword_c_o = {4{wdata_i[7:0]}};
            rdata_c_o = {{24{signed_i & byte_c[7]}}, byte_c};
         end
         default: misalign_c_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/data_mem_responder.sv
// Wait-stated data-memory responder: one request in flight, single-cycle response pulse.
module data_mem_responder
   import mem_bus_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 32,
   parameter int unsigned DEPTH         = 256,
   parameter int unsigned WAIT_STATES   = 2
) (
   input  logic                     i_CLK,
   input  logic                     i_RST,
   input  logic                     i_Req,
   input  logic                     i_WE,
   input  logic [ADDRESS_WIDTH-1:0] i_Addr,
   input  logic [DATA_WIDTH-1:0]    i_WData,
   input  logic [1:0]               i_Size,
   input  logic                     i_Signed,
   output logic                     o_Ready,
   output logic                     o_RValid,
   output logic [DATA_WIDTH-1:0]    o_RData,
   output logic                     o_Err
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     we_q, we_d, sgn_q, sgn_d, err_q, err_d;
   logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
   logic [1:0]               size_q, size_d;
   logic                     ready_q, ready_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

   logic [DATA_WIDTH-1:0]    mem_q [DEPTH];

   logic                     cur_we_c, cur_sgn_c, cur_err_c, chk_err_c, commit_c;
   logic [ADDRESS_WIDTH-1:0] cur_addr_c;
   logic [DATA_WIDTH-1:0]    cur_wdata_c, rword_c, rdata_c, wword_c;
   logic [1:0]               cur_size_c;
   logic [3:0]               wmask_c;
   logic                     misalign_c;
   logic [IDX_W-1:0]         widx_c;

   // In IDLE the live request is used so a zero-wait build can commit on the accept edge.
   always_comb begin
      if (state_q == IDLE) begin
         cur_we_c    = i_WE;
         cur_addr_c  = i_Addr;
         cur_wdata_c = i_WData;
         cur_size_c  = i_Size;
         cur_sgn_c   = i_Signed;
      end else begin
         cur_we_c    = we_q;
         cur_addr_c  = addr_q;
         cur_wdata_c = wdata_q;
         cur_size_c  = size_q;
         cur_sgn_c   = sgn_q;
      end
      widx_c    = cur_addr_c[IDX_W+1:2];
      rword_c   = mem_q[widx_c];
      chk_err_c = misalign_c | (|cur_addr_c[ADDRESS_WIDTH-1:IDX_W+2]);
      cur_err_c = (state_q == IDLE) ? chk_err_c : err_q;
   end

   mem_lane_align u_align (
      .size_i       (cur_size_c),
      .addr_lo_i    (cur_addr_c[1:0]),
      .signed_i     (cur_sgn_c),
      .wdata_i      (cur_wdata_c),
      .rword_i      (rword_c),
      .wmask_c_o    (wmask_c),
      .wword_c_o    (wword_c),
      .rdata_c_o    (rdata_c),
      .misalign_c_o (misalign_c)
   );

   // Next-state, request capture and response generation.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      size_d   = size_q;
      sgn_d    = sgn_q;
      err_d    = err_q;
      commit_c = 1'b0;
      rvalid_d = 1'b0;
      rdata_d  = '0;
      rerr_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (i_Req) begin
               we_d    = i_WE;
               addr_d  = i_Addr;
               wdata_d = i_WData;
               size_d  = i_Size;
               sgn_d   = i_Signed;
               err_d   = chk_err_c;
               cnt_d   = CNT_W'(WAIT_STATES);
               if (WAIT_STATES == 0) begin
                  commit_c = 1'b1;
                  state_d  = RESP;
               end else begin
                  state_d = BUSY;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               commit_c = 1'b1;
               state_d  = RESP;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (commit_c) begin
         rvalid_d = 1'b1;
         rerr_d   = cur_err_c;
         rdata_d  = (cur_we_c || cur_err_c) ? '0 : rdata_c;
      end
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ready_q  <= 1'b1;
         rvalid_q <= 1'b0;
         rdata_q  <= '0;
         rerr_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ready_q  <= ready_d;
         rvalid_q <= rvalid_d;
         rdata_q  <= rdata_d;
         rerr_q   <= rerr_d;
      end
   end

   always_ff @(posedge i_CLK) begin
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      sgn_q   <= sgn_d;
      err_q   <= err_d;
   end

   // Byte-masked RAM write; contents survive reset.
   always_ff @(posedge i_CLK) begin
      if (!i_RST && commit_c && cur_we_c && !cur_err_c) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_c[b]) mem_q[widx_c][8*b +: 8] <= wword_c[8*b +: 8];
         end
      end
   end

   assign o_Ready  = ready_q;
   assign o_RValid = rvalid_q;
   assign o_RData  = rdata_q;
   assign o_Err    = rerr_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder (WAIT_STATES=2 main instance, WAIT_STATES=0 side instance).
module tb_data_mem_responder;
   import mem_bus_pkg::*;

   localparam int WS = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic        req, we, sgn, ready, rvalid, err;
   logic [31:0] addr, wdata, rdata;
   logic [1:0]  size;

   logic        z_req, z_we, z_sgn, z_ready, z_rvalid, z_err;
   logic [31:0] z_addr, z_wdata, z_rdata;
   logic [1:0]  z_size;

   data_mem_responder #(.WAIT_STATES(WS)) u_dut (
      .i_CLK(clk), .i_RST(rst), .i_Req(req), .i_WE(we), .i_Addr(addr),
      .i_WData(wdata), .i_Size(size), .i_Signed(sgn), .o_Ready(ready),
      .o_RValid(rvalid), .o_RData(rdata), .o_Err(err)
   );

   data_mem_responder #(.WAIT_STATES(0)) u_ws0 (
      .i_CLK(clk), .i_RST(rst), .i_Req(z_req), .i_WE(z_we), .i_Addr(z_addr),
      .i_WData(z_wdata), .i_Size(z_size), .i_Signed(z_sgn), .o_Ready(z_ready),
      .o_RValid(z_rvalid), .o_RData(z_rdata), .o_Err(z_err)
   );

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   last_acc = -1;
   logic prev_rv = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: every response pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rvalid) begin
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_rvalid cyc=%0d rdata=%h err=%b", cyc, rdata, err);
         end else begin
            e = sb.pop_front();
            checks++;
            if (rdata !== e.data || err !== e.err || cyc != e.cyc) begin
               errors++;
               $display("FAIL resp got data=%h err=%b cyc=%0d, want data=%h err=%b cyc=%0d",
                        rdata, err, cyc, e.data, e.err, e.cyc);
            end
         end
         if (prev_rv) begin
            errors++;
            $display("FAIL rvalid_twice cyc=%0d got two consecutive pulses, want one", cyc);
         end
      end
      prev_rv = rvalid;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Presents a request and keeps i_Req high; returns just after the accept edge.
   task automatic do_req(input logic r_we, input logic [31:0] r_addr, input logic [31:0] r_wdata,
                         input logic [1:0] r_size, input logic r_sgn,
                         input logic [31:0] e_data, input logic e_err, input bit track);
      int   n;
      exp_t e;
      @(negedge clk);
      req = 1'b1; we = r_we; addr = r_addr; wdata = r_wdata; size = r_size; sgn = r_sgn;
      n = 0;
      while (!ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!ready) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout addr=%h got ready=0 want ready=1", r_addr);
      end else begin
         if (last_acc >= 0) begin
            checks++;
            if (cyc - last_acc != WS + 2) begin
               errors++;
               $display("FAIL throughput got %0d cycles between accepts want %0d",
                        cyc - last_acc, WS + 2);
            end
         end
         last_acc = cyc;
         if (track) begin
            e.data = e_data;
            e.err  = e_err;
            e.cyc  = cyc + WS + 1;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drop_req();
      req = 1'b0;
      last_acc = -1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      req = 1'b0; we = 1'b0; addr = '0; wdata = '0; size = SIZE_WORD; sgn = 1'b0;
      z_req = 1'b0; z_we = 1'b0; z_addr = '0; z_wdata = '0; z_size = SIZE_WORD; z_sgn = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", 32'(ready), 32'h1);
      chk("reset_rvalid", 32'(rvalid), 32'h0);
      chk("reset_rdata", rdata, 32'h0);
      chk("reset_err", 32'(err), 32'h0);
      rst = 1'b0;

      // Held-request chain: every accept must be WS+2 cycles after the previous.
      do_req(1'b1, 32'h10, 32'hDEADBEEF, SIZE_WORD, 1'b0, 32'h0,        1'b0, 1'b1);
      do_req(1'b0, 32'h10, 32'h0,        SIZE_WORD, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1);
      do_req(1'b1, 32'h13, 32'h00000080, SIZE_BYTE, 1'b0, 32'h0,        1'b0, 1'b1);
      do_req(1'b0, 32'h13, 32'h0,        SIZE_BYTE, 1'b1, 32'hFFFFFF80, 1'b0, 1'b1);
      do_req(1'b0, 32'h13, 32'h0,        SIZE_BYTE, 1'b0, 32'h00000080, 1'b0, 1'b1);
      do_req(1'b0, 32'h10, 32'h0,        SIZE_WORD, 1'b1, 32'h80ADBEEF, 1'b0, 1'b1);
      do_req(1'b0, 32'h11, 32'h0,        SIZE_BYTE, 1'b1, 32'hFFFFFFBE, 1'b0, 1'b1);
      do_req(1'b1, 32'h20, 32'h00000000, SIZE_WORD, 1'b0, 32'h0,        1'b0, 1'b1);
      do_req(1'b1, 32'h22, 32'h00008001, SIZE_HALF, 1'b0, 32'h0,        1'b0, 1'b1);
      do_req(1'b0, 32'h22, 32'h0,        SIZE_HALF, 1'b1, 32'hFFFF8001, 1'b0, 1'b1);
      do_req(1'b0, 32'h22, 32'h0,        SIZE_HALF, 1'b0, 32'h00008001, 1'b0, 1'b1);
      do_req(1'b0, 32'h21, 32'h0,        SIZE_HALF, 1'b1, 32'h0,        1'b1, 1'b1);
      do_req(1'b1, 32'h21, 32'h0000FFFF, SIZE_HALF, 1'b0, 32'h0,        1'b1, 1'b1);
      do_req(1'b0, 32'h20, 32'h0,        SIZE_WORD, 1'b0, 32'h80010000, 1'b0, 1'b1);
      do_req(1'b0, 32'h10, 32'h0,        SIZE_RSVD, 1'b0, 32'h0,        1'b1, 1'b1);
      do_req(1'b1, 32'h10, 32'h11111111, SIZE_RSVD, 1'b0, 32'h0,        1'b1, 1'b1);
      do_req(1'b0, 32'h400, 32'h0,       SIZE_WORD, 1'b0, 32'h0,        1'b1, 1'b1);
      do_req(1'b1, 32'h410, 32'h22222222, SIZE_WORD, 1'b0, 32'h0,       1'b1, 1'b1);
      do_req(1'b0, 32'h12, 32'h0,        SIZE_WORD, 1'b0, 32'h0,        1'b1, 1'b1);
      do_req(1'b0, 32'h10, 32'h0,        SIZE_WORD, 1'b0, 32'h80ADBEEF, 1'b0, 1'b1);
      do_req(1'b1, 32'h30, 32'h0BADF00D, SIZE_WORD, 1'b0, 32'h0,        1'b0, 1'b1);
      drop_req();
      drain();

      // Reset while a store is in BUSY: no response, no write.
      do_req(1'b1, 32'h30, 32'h12345678, SIZE_WORD, 1'b0, 32'h0, 1'b0, 1'b0);
      drop_req();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_ready", 32'(ready), 32'h1);
      chk("midrst_rvalid", 32'(rvalid), 32'h0);
      rst = 1'b0;
      do_req(1'b0, 32'h30, 32'h0, SIZE_WORD, 1'b0, 32'h0BADF00D, 1'b0, 1'b1);
      drop_req();
      drain();

      // Zero-wait-state instance: response in the cycle after accept.
      @(negedge clk);
      chk("ws0_ready", 32'(z_ready), 32'h1);
      z_req = 1'b1; z_we = 1'b1; z_addr = 32'h4; z_wdata = 32'hCAFEF00D; z_size = SIZE_WORD;
      @(posedge clk);
      #1 z_req = 1'b0;
      @(negedge clk);
      chk("ws0_st_rvalid", 32'(z_rvalid), 32'h1);
      chk("ws0_st_rdata", z_rdata, 32'h0);
      @(negedge clk);
      chk("ws0_idle_rvalid", 32'(z_rvalid), 32'h0);
      z_req = 1'b1; z_we = 1'b0; z_addr = 32'h4; z_size = SIZE_WORD;
      @(posedge clk);
      #1 z_req = 1'b0;
      @(negedge clk);
      chk("ws0_ld_rvalid", 32'(z_rvalid), 32'h1);
      chk("ws0_ld_rdata", z_rdata, 32'hCAFEF00D);
      chk("ws0_ld_err", 32'(z_err), 32'h0);

      repeat (4) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
